// File: rtl/reg_bank_nano.sv
// reg_bank_nano
//   Register bank with DEPTH words of WIDTH bits. It has one write port and two
//   independent combinational read ports. A busy scoreboard tracks which registers
//   have a write pending, so the decode stage can detect hazards.
//
//   Parameters
//     WIDTH     data word width (>=1)
//     DEPTH     number of registers (>=2, power of two)
//     ZERO_REG  1: register 0 reads as zero, ignores writes and is never busy
//     BYPASS    1: a read of the address being written this cycle returns wdata
//
//   Ports
//     clk                    rising-edge clock
//     rst                    asynchronous, active-low reset
//     we, waddr, wdata       write port, sampled on the rising edge
//     raddr_a, raddr_b       read addresses
//     rdata_a, rdata_b       read data (combinational)
//     claim_en, claim_addr   mark a register as having a pending write
//     busy_a, busy_b         pending-write flag of each read address
//     busy_any               OR of every busy bit
module reg_bank_nano #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             busy_any
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic             wr_ok_s;
  logic             claim_ok_s;

  // Qualify write and claim. Register 0 is excluded when it is the hardwired zero.
  always_comb begin
    wr_ok_s    = we;
    claim_ok_s = claim_en;
    if ((ZERO_REG != 0) && (waddr == ADDR_ZERO)) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = we;
    end
    if ((ZERO_REG != 0) && (claim_addr == ADDR_ZERO)) begin
      claim_ok_s = 1'b0;
    end else begin
      claim_ok_s = claim_en;
    end
  end

  // Compute the next scoreboard state. A write clears its bit and a claim sets its bit.
  // A claim takes priority when both target the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      busy_nxt_s[i] = (claim_ok_s && (claim_addr == AW'(i))) ||
                      (busy_r[i] && !(wr_ok_s && (waddr == AW'(i))));
    end
  end

  // Update the register array and the scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[waddr] <= wdata;
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Drive read port A. The output is forced to zero during reset, so a write that is
  // asserted during reset cannot reach the output through the bypass path.
  always_comb begin
    rdata_a = {WIDTH{1'b0}};
    busy_a  = 1'b0;
    if (!rst) begin
      rdata_a = {WIDTH{1'b0}};
      busy_a  = 1'b0;
    end else if ((BYPASS != 0) && wr_ok_s && (waddr == raddr_a)) begin
      rdata_a = wdata;
      busy_a  = claim_ok_s && (claim_addr == raddr_a);
    end else if ((ZERO_REG != 0) && (raddr_a == ADDR_ZERO)) begin
      rdata_a = {WIDTH{1'b0}};
      busy_a  = 1'b0;
    end else begin
      rdata_a = mem_r[raddr_a];
      busy_a  = busy_r[raddr_a];
    end
  end

  // Drive read port B. It uses the same logic as port A.
  always_comb begin
    rdata_b = {WIDTH{1'b0}};
    busy_b  = 1'b0;
    if (!rst) begin
      rdata_b = {WIDTH{1'b0}};
      busy_b  = 1'b0;
    end else if ((BYPASS != 0) && wr_ok_s && (waddr == raddr_b)) begin
      rdata_b = wdata;
      busy_b  = claim_ok_s && (claim_addr == raddr_b);
    end else if ((ZERO_REG != 0) && (raddr_b == ADDR_ZERO)) begin
      rdata_b = {WIDTH{1'b0}};
      busy_b  = 1'b0;
    end else begin
      rdata_b = mem_r[raddr_b];
      busy_b  = busy_r[raddr_b];
    end
  end

  // Aggregate the pending-write flag.
  always_comb begin
    busy_any = 1'b0;
    if (!rst) begin
      busy_any = 1'b0;
    end else begin
      busy_any = |busy_r;
    end
  end

endmodule

// File: tb/tb_reg_bank_nano.sv
// tb_reg_bank_nano
//   Directed bench for reg_bank_nano. It uses two instances that share all inputs:
//     u0 uses the defaults (ZERO_REG=1, BYPASS=1)
//     u1 uses ZERO_REG=0 and BYPASS=0
//   Expected values are hand-computed. The sweep uses a small array model.
module tb_reg_bank_nano;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic       claim_en;
  logic [2:0] claim_addr;

  logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic       busy_a0, busy_b0, busy_any0, busy_a1, busy_b1, busy_any1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m0 [8];
  logic [7:0] m1 [8];

  always #5 clk = ~clk;

  reg_bank_nano u0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_a(busy_a0), .busy_b(busy_b0), .busy_any(busy_any0)
  );

  reg_bank_nano #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_a(busy_a1), .busy_b(busy_b1), .busy_any(busy_any1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the falling edge. Comparisons that follow
  // this task see the combinational response. The state update happens at the next
  // rising edge.
  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic c, input logic [2:0] ca,
                       input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; claim_en = c; claim_addr = ca;
    raddr_a = ra; raddr_b = rb;
    #1;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
    claim_en = 1'b0; claim_addr = 3'd0; raddr_a = 3'd0; raddr_b = 3'd0;
    #2;
    check("reset_rdata_a", rdata_a0, 32'h0);
    check("reset_busy_any", busy_any0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Write then read on both ports: r3 = A5
    drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd0, 3'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd3);
    check("wr_r3_a", rdata_a0, 32'hA5);
    check("wr_r3_b", rdata_b0, 32'hA5);
    check("wr_r3_a_nb", rdata_a1, 32'hA5);

    // Bypass compared with no bypass: r5 = 3C
    drive(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd5, 3'd3);
    check("bypass_a", rdata_a0, 32'h3C);
    check("nobypass_a_old", rdata_a1, 32'h00);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd3);
    check("nobypass_a_after", rdata_a1, 32'h3C);

    // Zero register: a write and a claim of r0 are ignored on u0. They take effect on u1.
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
    check("zero_bypass_rdata", rdata_a0, 32'h00);
    check("zero_bypass_busy", busy_a0, 32'h0);
    check("nozero_old_rdata", rdata_a1, 32'h00);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    check("zero_rdata", rdata_a0, 32'h00);
    check("zero_busy", busy_a0, 32'h0);
    check("zero_busy_any", busy_any0, 32'h0);
    check("nozero_rdata", rdata_a1, 32'hFF);
    check("nozero_busy_claim_wins", busy_a1, 32'h1);
    drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd0, 3'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    check("nozero_busy_cleared", busy_any1, 32'h0);

    // Scoreboard: claim r2, then write r2
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0, 3'd2);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd2);
    check("claim_busy_b", busy_b0, 32'h1);
    check("claim_busy_any", busy_any0, 32'h1);
    drive(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd0, 3'd2);
    check("wr_busy_b_bypass", busy_b0, 32'h0);
    check("wr_busy_b_nobypass", busy_b1, 32'h1);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd2);
    check("wr_busy_b_after", busy_b0, 32'h0);
    check("wr_busy_any_after", busy_any0, 32'h0);
    check("wr_r2_data", rdata_b0, 32'h11);

    // Claim and write the same register in one cycle: the claim wins.
    drive(1'b1, 3'd4, 8'h5A, 1'b1, 3'd4, 3'd4, 3'd0);
    check("same_busy_bypass", busy_a0, 32'h1);
    check("same_rdata_bypass", rdata_a0, 32'h5A);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0);
    check("same_rdata", rdata_a0, 32'h5A);
    check("same_busy", busy_a0, 32'h1);

    // Claim r6 and write r4 in the same cycle: both updates apply.
    drive(1'b1, 3'd4, 8'h5A, 1'b1, 3'd6, 3'd6, 3'd4);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd4);
    check("diff_busy6", busy_a0, 32'h1);
    check("diff_busy4", busy_b0, 32'h0);
    drive(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 3'd0, 3'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    check("diff_clear_any", busy_any0, 32'h0);

    // Sweep all addresses with random nonzero data.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(1, 255));
      m0[i] = (i == 0) ? 8'h00 : d;
      m1[i] = d;
      drive(1'b1, 3'(i), d, 1'b0, 3'd0, 3'd0, 3'd0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(i), 3'(7 - i));
      check("sweep_a0", rdata_a0, {24'h0, m0[i]});
      check("sweep_b0", rdata_b0, {24'h0, m0[7 - i]});
      check("sweep_a1", rdata_a1, {24'h0, m1[i]});
    end

    // Reset in the middle of operation. The write asserted during reset must be ignored.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd3, 3'd7);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd7);
    check("pre_rst_busy_any", busy_any0, 32'h1);
    check("pre_rst_rdata", rdata_a0, {24'h0, m0[3]});
    rst = 1'b0; we = 1'b1; waddr = 3'd3; wdata = 8'h77;
    #1;
    check("rst_rdata_a", rdata_a0, 32'h0);
    check("rst_rdata_b", rdata_b0, 32'h0);
    check("rst_busy_any", busy_any0, 32'h0);
    check("rst_busy_b", busy_b0, 32'h0);
    check("rst_rdata_a_nb", rdata_a1, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_rdata", rdata_a0, 32'h0);
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    #1;
    check("post_rst_r3", rdata_a0, 32'h0);
    check("post_rst_r3_nb", rdata_a1, 32'h0);
    check("post_rst_busy_any", busy_any0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
